// File: rtl/width_converter_n_to_m_if.sv
// Word-in / beat-out stream bundle for the width downsizer.
// The converter takes the slave view; producer/consumer logic takes the master view.
interface width_converter_n_to_m_if #(
    parameter int unsigned InWidth  = 32,
    parameter int unsigned OutWidth = 8,
    parameter int unsigned CntW     = $clog2(InWidth / OutWidth + 1)
);
    logic                sink_valid;
    logic                sink_ready;
    logic [InWidth-1:0]  sink_data;
    logic [CntW-1:0]     sink_nbeats;
    logic                sink_last;
    logic                source_valid;
    logic                source_ready;
    logic [OutWidth-1:0] source_data;
    logic                source_last;
    logic                flush;
    logic                busy;

    modport slave (
        input  sink_valid, sink_data, sink_nbeats, sink_last, source_ready, flush,
        output sink_ready, source_valid, source_data, source_last, busy
    );

    modport master (
        output sink_valid, sink_data, sink_nbeats, sink_last, source_ready, flush,
        input  sink_ready, source_valid, source_data, source_last, busy
    );
endinterface

// File: rtl/width_converter_n_to_m.sv
// Downsizes InWidth-bit words into OutWidth-bit beats, LSB beat first, with
// per-word beat count, packet-end marking, flush and optional zero-bubble refill.
module width_converter_n_to_m #(
    parameter int unsigned InWidth    = 32,
    parameter int unsigned OutWidth   = 8,
    parameter bit          ZeroBubble = 1'b1
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    width_converter_n_to_m_if.slave  bus
);
    localparam int unsigned Ratio = InWidth / OutWidth;
    localparam int unsigned CntW  = $clog2(Ratio + 1);

    localparam logic [CntW-1:0] RatioCnt = CntW'(Ratio);
    localparam logic [CntW-1:0] OneCnt   = CntW'(1);

    if ((OutWidth < 8) || (InWidth < OutWidth) || ((InWidth % OutWidth) != 0)) begin : g_cfg_err
        $error("width_converter_n_to_m: InWidth must be a non-zero multiple of OutWidth >= 8");
    end

    typedef struct packed {
        logic [InWidth-1:0] sreg;
        logic [CntW-1:0]    cnt;
        logic               lreg;
    } state_t;

    state_t          q, d;
    logic            active;
    logic            final_beat;
    logic            sink_hs;
    logic            src_hs;
    logic [CntW-1:0] nbeats_eff;

    assign active     = (q.cnt != '0);
    assign final_beat = (q.cnt == OneCnt);

    assign bus.source_valid = active;
    assign bus.source_data  = q.sreg[OutWidth-1:0];
    assign bus.source_last  = q.lreg & final_beat;
    assign bus.busy         = active;

    // Zero-bubble refill is a combinational source_ready -> sink_ready path.
    assign bus.sink_ready = !bus.flush &&
                            (!active || (ZeroBubble && final_beat && bus.source_ready));

    assign sink_hs = bus.sink_valid & bus.sink_ready;
    assign src_hs  = active & bus.source_ready;

    // Zero and oversized beat counts both mean a full word.
    assign nbeats_eff = ((bus.sink_nbeats == '0) || (bus.sink_nbeats > RatioCnt))
                        ? RatioCnt : bus.sink_nbeats;

    always_comb begin
        d = q;
        if (bus.flush) begin
            d = '0;
        end else if (sink_hs) begin
            d.sreg = bus.sink_data;
            d.cnt  = nbeats_eff;
            d.lreg = bus.sink_last;
        end else if (src_hs) begin
            d.sreg = q.sreg >> OutWidth;
            d.cnt  = q.cnt - OneCnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    // A stalled beat must not move until the consumer takes it.
    a_stall_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (active && !bus.source_ready && !bus.flush)
        |=> (bus.source_valid && $stable(bus.source_data) && $stable(bus.source_last))
    );

    a_cnt_bound: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (q.cnt <= RatioCnt)
    );
endmodule

// File: tb/tb_width_converter_n_to_m.sv
// Bench for width_converter_n_to_m: directed scenarios plus random traffic
// scored against a word/beat-index reference model on 32->8 (both refill modes) and 64->16.
module tb_width_converter_n_to_m;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    width_converter_n_to_m_if #(.InWidth(32), .OutWidth(8))  ifa ();
    width_converter_n_to_m_if #(.InWidth(32), .OutWidth(8))  ifb ();
    width_converter_n_to_m_if #(.InWidth(64), .OutWidth(16)) ifc ();

    width_converter_n_to_m #(.InWidth(32), .OutWidth(8), .ZeroBubble(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_ni), .bus(ifa.slave));
    width_converter_n_to_m #(.InWidth(32), .OutWidth(8), .ZeroBubble(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_ni), .bus(ifb.slave));
    width_converter_n_to_m #(.InWidth(64), .OutWidth(16), .ZeroBubble(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_ni), .bus(ifc.slave));

    int n_pass = 0;
    int n_chk  = 0;

    // Model: word held, beats still owed, index of next beat, packet-end flag.
    logic [31:0] m_word [2];
    int          m_rem  [2];
    int          m_idx  [2];
    bit          m_last [2];

    task automatic set_in(input int d, input bit v, input logic [31:0] data, input logic [2:0] nb,
                          input bit l, input bit rdy, input bit fl);
        if (d == 0) begin
            ifa.sink_valid = v; ifa.sink_data = data; ifa.sink_nbeats = nb;
            ifa.sink_last = l; ifa.source_ready = rdy; ifa.flush = fl;
        end else begin
            ifb.sink_valid = v; ifb.sink_data = data; ifb.sink_nbeats = nb;
            ifb.sink_last = l; ifb.source_ready = rdy; ifb.flush = fl;
        end
    endtask

    // One cycle on DUT d: check outputs against the model mid-cycle, then advance.
    task automatic step(input int d, output bit beat, output logic [7:0] bd, output bit bl,
                        output bit acc);
        logic sv, sr, sl, bsy, vin, rdy, fl, lin;
        logic [7:0] sdat, ed;
        logic [31:0] din;
        logic [2:0] nb;
        bit ev, el, er;
        string nm;
        #1;
        if (d == 0) begin
            sv = ifa.source_valid; sr = ifa.sink_ready; sl = ifa.source_last; bsy = ifa.busy;
            sdat = ifa.source_data; vin = ifa.sink_valid; rdy = ifa.source_ready; fl = ifa.flush;
            din = ifa.sink_data; nb = ifa.sink_nbeats; lin = ifa.sink_last; nm = "zb1";
        end else begin
            sv = ifb.source_valid; sr = ifb.sink_ready; sl = ifb.source_last; bsy = ifb.busy;
            sdat = ifb.source_data; vin = ifb.sink_valid; rdy = ifb.source_ready; fl = ifb.flush;
            din = ifb.sink_data; nb = ifb.sink_nbeats; lin = ifb.sink_last; nm = "zb0";
        end
        ev = (m_rem[d] > 0);
        ed = ev ? m_word[d][m_idx[d]*8 +: 8] : 8'h00;
        el = (m_rem[d] == 1) && m_last[d];
        er = !fl && ((m_rem[d] == 0) || ((d == 0) && (m_rem[d] == 1) && rdy));
        if (sv !== ev) $display("FAIL %s source_valid: got %b expected %b", nm, sv, ev); else n_pass++;
        n_chk++;
        if (bsy !== ev) $display("FAIL %s busy: got %b expected %b", nm, bsy, ev); else n_pass++;
        n_chk++;
        if (sr !== er) $display("FAIL %s sink_ready: got %b expected %b", nm, sr, er); else n_pass++;
        n_chk++;
        if (sl !== el) $display("FAIL %s source_last: got %b expected %b", nm, sl, el); else n_pass++;
        n_chk++;
        if (ev) begin
            if (sdat !== ed) $display("FAIL %s source_data: got %h expected %h", nm, sdat, ed);
            else n_pass++;
            n_chk++;
        end
        beat = ev && rdy;
        bd   = sdat;
        bl   = sl;
        acc  = vin && er;
        if (fl) begin
            m_rem[d] = 0;
        end else if (acc) begin
            m_word[d] = din;
            m_rem[d]  = ((nb == 0) || (nb > 4)) ? 4 : int'(nb);
            m_idx[d]  = 0;
            m_last[d] = lin;
        end else if (beat) begin
            m_rem[d]--;
            m_idx[d]++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        bit b, bl, a;
        logic [7:0] bd;
        set_in(d, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (6) step(d, b, bd, bl, a);
    endtask

    task automatic test_reset();
        if ({ifa.source_valid, ifa.source_last, ifa.busy, ifa.sink_ready} !== 4'b0001)
            $display("FAIL reset_ctrl_a: got %b expected 0001",
                     {ifa.source_valid, ifa.source_last, ifa.busy, ifa.sink_ready});
        else n_pass++;
        n_chk++;
        if (ifa.source_data !== 8'h00) $display("FAIL reset_data_a: got %h expected 00", ifa.source_data);
        else n_pass++;
        n_chk++;
        if ({ifb.source_valid, ifb.source_last, ifb.busy, ifb.sink_ready} !== 4'b0001)
            $display("FAIL reset_ctrl_b: got %b expected 0001",
                     {ifb.source_valid, ifb.source_last, ifb.busy, ifb.sink_ready});
        else n_pass++;
        n_chk++;
        if ({ifc.source_valid, ifc.source_last, ifc.busy, ifc.sink_ready} !== 4'b0001)
            $display("FAIL reset_ctrl_c: got %b expected 0001",
                     {ifc.source_valid, ifc.source_last, ifc.busy, ifc.sink_ready});
        else n_pass++;
        n_chk++;
        if (ifc.source_data !== 16'h0) $display("FAIL reset_data_c: got %h expected 0000", ifc.source_data);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_full_word();
        bit b, bl, a;
        logic [7:0] bd;
        logic [7:0] expb [4];
        int n = 0, first = -1, lastc = -1;
        expb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        set_in(0, 1'b1, 32'hDDCCBBAA, 3'd0, 1'b1, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        if (a !== 1'b1) $display("FAIL full_accept: got %b expected 1", a); else n_pass++;
        n_chk++;
        set_in(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            step(0, b, bd, bl, a);
            if (b) begin
                if (n < 4) begin
                    if (bd !== expb[n]) $display("FAIL full_beat%0d: got %h expected %h", n, bd, expb[n]);
                    else n_pass++;
                    n_chk++;
                    if (bl !== (n == 3)) $display("FAIL full_last%0d: got %b expected %b", n, bl, n == 3);
                    else n_pass++;
                    n_chk++;
                end
                if (first < 0) first = cyc;
                lastc = cyc;
                n++;
            end
        end
        if (n != 4 || first != 0 || lastc != 3)
            $display("FAIL full_timing: got beats=%0d first=%0d last=%0d expected 4/0/3", n, first, lastc);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_partial();
        bit b, bl, a;
        logic [7:0] bd;
        int n = 0;
        set_in(0, 1'b1, 32'h44332211, 3'd2, 1'b1, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        set_in(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            step(0, b, bd, bl, a);
            if (b) begin
                if ({bd, bl} !== ((n == 0) ? {8'h11, 1'b0} : {8'h22, 1'b1}))
                    $display("FAIL partial_beat%0d: got %h/%b", n, bd, bl);
                else n_pass++;
                n_chk++;
                n++;
            end
        end
        if (n != 2 || ifa.source_valid !== 1'b0)
            $display("FAIL partial_count: got beats=%0d valid=%b expected 2/0", n, ifa.source_valid);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_back_to_back(input int d);
        bit b, bl, a, acc2_beat = 1'b0;
        logic [7:0] bd, acc2_data = 8'h00;
        logic [31:0] w [2];
        int wi = 0, n = 0, first = -1, lastc = -1;
        w = '{32'h03020100, 32'h07060504};
        for (int cyc = 0; cyc < 16; cyc++) begin
            set_in(d, wi < 2, w[(wi < 2) ? wi : 1], 3'd4, wi == 1, 1'b1, 1'b0);
            step(d, b, bd, bl, a);
            if (b) begin
                if (bd !== 8'(n)) $display("FAIL b2b_%0d_beat%0d: got %h expected %h", d, n, bd, 8'(n));
                else n_pass++;
                n_chk++;
                if (first < 0) first = cyc;
                lastc = cyc;
                n++;
            end
            if (a) begin
                if (wi == 1) begin acc2_beat = b; acc2_data = bd; end
                wi++;
            end
        end
        if (n != 8 || (lastc - first + 1) != ((d == 0) ? 8 : 9))
            $display("FAIL b2b_%0d_span: got beats=%0d span=%0d expected 8/%0d", d, n,
                     lastc - first + 1, (d == 0) ? 8 : 9);
        else n_pass++;
        n_chk++;
        if (d == 0) begin
            if ({acc2_beat, acc2_data} !== {1'b1, 8'h03})
                $display("FAIL b2b_accept_on_03: got beat=%b data=%h expected 1/03", acc2_beat, acc2_data);
            else n_pass++;
            n_chk++;
        end else begin
            if (acc2_beat !== 1'b0) $display("FAIL b2b_idle_accept: got beat=%b expected 0", acc2_beat);
            else n_pass++;
            n_chk++;
        end
        drain(d);
    endtask

    task automatic test_backpressure();
        bit b, bl, a, acc_seen = 1'b0;
        logic [7:0] bd;
        logic [7:0] expb [4];
        bit pat [4];
        int n = 0;
        expb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_in(0, 1'b1, 32'hDDCCBBAA, 3'd0, 1'b1, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        for (int k = 0; k < 30 && n < 4; k++) begin
            set_in(0, 1'b1, 32'h11111111, 3'd4, 1'b0, pat[k % 4], 1'b0);
            step(0, b, bd, bl, a);
            if (b) begin
                if (bd !== expb[n]) $display("FAIL bp_beat%0d: got %h expected %h", n, bd, expb[n]);
                else n_pass++;
                n_chk++;
                n++;
            end
            if (a) begin
                acc_seen = 1'b1;
                if (!(b && bl)) $display("FAIL bp_early_accept: got beat=%b last=%b expected 1/1", b, bl);
                else n_pass++;
                n_chk++;
            end
        end
        if (n != 4 || !acc_seen)
            $display("FAIL bp_done: got beats=%0d accepted=%b expected 4/1", n, acc_seen);
        else n_pass++;
        n_chk++;
        drain(0);
    endtask

    task automatic test_flush();
        bit b, bl, a;
        logic [7:0] bd;
        set_in(0, 1'b1, 32'hDDCCBBAA, 3'd0, 1'b1, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        set_in(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        if ({b, bd} !== {1'b1, 8'hAA}) $display("FAIL flush_first_beat: got %b/%h expected 1/aa", b, bd);
        else n_pass++;
        n_chk++;
        set_in(0, 1'b1, 32'h55667788, 3'd0, 1'b1, 1'b1, 1'b1);
        step(0, b, bd, bl, a);
        if (a !== 1'b0) $display("FAIL flush_no_accept: got %b expected 0", a); else n_pass++;
        n_chk++;
        if ({ifa.source_valid, ifa.source_data} !== 9'h000)
            $display("FAIL flush_cleared: got valid=%b data=%h expected 0/00", ifa.source_valid, ifa.source_data);
        else n_pass++;
        n_chk++;
        set_in(0, 1'b1, 32'h55667788, 3'd0, 1'b1, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        if (a !== 1'b1) $display("FAIL flush_reaccept: got %b expected 1", a); else n_pass++;
        n_chk++;
        set_in(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        step(0, b, bd, bl, a);
        if ({b, bd} !== {1'b1, 8'h88}) $display("FAIL flush_next_word: got %b/%h expected 1/88", b, bd);
        else n_pass++;
        n_chk++;
        drain(0);
    endtask

    task automatic test_random(input int d, input int cycles);
        bit b, bl, a;
        logic [7:0] bd;
        for (int i = 0; i < cycles; i++) begin
            set_in(d, $urandom_range(0, 3) != 0, 32'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            step(d, b, bd, bl, a);
        end
        drain(d);
    endtask

    task automatic test_wide_and_reset();
        logic [63:0] w;
        w = {$urandom, $urandom};
        ifc.sink_valid = 1'b1; ifc.sink_data = w; ifc.sink_nbeats = 3'd3;
        ifc.sink_last = 1'b1; ifc.source_ready = 1'b1; ifc.flush = 1'b0;
        #1;
        if (ifc.sink_ready !== 1'b1) $display("FAIL wide_ready: got %b expected 1", ifc.sink_ready);
        else n_pass++;
        n_chk++;
        @(negedge clk);
        ifc.sink_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({ifc.source_valid, ifc.source_data, ifc.source_last} !== {1'b1, w[i*16 +: 16], i == 2})
                $display("FAIL wide_beat%0d: got %b/%h/%b expected 1/%h/%b", i, ifc.source_valid,
                         ifc.source_data, ifc.source_last, w[i*16 +: 16], i == 2);
            else n_pass++;
            n_chk++;
            @(negedge clk);
        end
        #1;
        if (ifc.source_valid !== 1'b0) $display("FAIL wide_idle: got %b expected 0", ifc.source_valid);
        else n_pass++;
        n_chk++;
        @(negedge clk);
        ifc.sink_valid = 1'b1; ifc.sink_data = ~w; ifc.sink_nbeats = 3'd0;
        @(negedge clk);
        ifc.sink_valid = 1'b0; ifc.source_ready = 1'b0;
        #1;
        if (ifc.source_valid !== 1'b1) $display("FAIL wide_midword: got %b expected 1", ifc.source_valid);
        else n_pass++;
        n_chk++;
        #2 rst_ni = 1'b0;
        #1;
        if ({ifc.source_valid, ifc.source_last, ifc.busy, ifc.sink_ready} !== 4'b0001)
            $display("FAIL async_reset_ctrl: got %b expected 0001",
                     {ifc.source_valid, ifc.source_last, ifc.busy, ifc.sink_ready});
        else n_pass++;
        n_chk++;
        if (ifc.source_data !== 16'h0) $display("FAIL async_reset_data: got %h expected 0000", ifc.source_data);
        else n_pass++;
        n_chk++;
        @(negedge clk);
        rst_ni = 1'b1;
        m_rem = '{0, 0};
        ifc.source_ready = 1'b1;
        @(negedge clk);
        #1;
        if (ifc.source_valid !== 1'b0) $display("FAIL reset_discard: got %b expected 0", ifc.source_valid);
        else n_pass++;
        n_chk++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_word = '{32'h0, 32'h0};
        m_rem  = '{0, 0};
        m_idx  = '{0, 0};
        m_last = '{1'b0, 1'b0};
        set_in(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        set_in(1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        ifc.sink_valid = 1'b0; ifc.sink_data = '0; ifc.sink_nbeats = '0;
        ifc.sink_last = 1'b0; ifc.source_ready = 1'b1; ifc.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_partial();
        test_back_to_back(0);
        test_back_to_back(1);
        test_backpressure();
        test_flush();
        test_random(0, 400);
        test_random(1, 400);
        test_wide_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
